// File: rtl/jteeprom_pkg.sv
// jteeprom_pkg: shared types and helpers for the 93C46/ER5911-style EEPROM host.
//   op_e     : request operation codes presented on the host op port.
//   OPC_*    : 4-bit opcodes as they appear on the serial wire.
//   state_e  : host FSM states.
//   cmd_len  : serial command length after the start bit.
//   addr_w / data_w : word address / data widths for each organisation.
package jteeprom_pkg;

  typedef enum logic [2:0] {
    OP_READ  = 3'd0,
    OP_WRITE = 3'd1,
    OP_EWEN  = 3'd2,
    OP_EWDS  = 3'd3,
    OP_ERAL  = 3'd4
  } op_e;

  localparam logic [3:0] OPC_READ  = 4'b1000;
  localparam logic [3:0] OPC_WRITE = 4'b0100;
  localparam logic [3:0] OPC_EWEN  = 4'b0011;
  localparam logic [3:0] OPC_EWDS  = 4'b0000;
  localparam logic [3:0] OPC_ERAL  = 4'b0010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_CMD   = 3'd2,
    ST_RDAT  = 3'd3,
    ST_WDAT  = 3'd4,
    ST_BUSYW = 3'd5,
    ST_DESEL = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  // Rises after the start bit: 4-bit opcode + address (+2-bit pad for x16).
  function automatic int cmd_len(input int prog);
    return (prog != 0) ? 12 : 11;
  endfunction

  function automatic int addr_w(input int prog);
    return (prog != 0) ? 6 : 7;
  endfunction

  function automatic int data_w(input int prog);
    return (prog != 0) ? 16 : 8;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

  function automatic logic [3:0] opcode_of(input logic [2:0] op);
    logic [3:0] opc;
    case (op)
      OP_READ:  opc = OPC_READ;
      OP_WRITE: opc = OPC_WRITE;
      OP_EWEN:  opc = OPC_EWEN;
      OP_EWDS:  opc = OPC_EWDS;
      OP_ERAL:  opc = OPC_ERAL;
      default:  opc = OPC_EWDS;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/jt5911_sclkgen.sv
// jt5911_sclkgen: serial clock generator for the EEPROM host.
//   clk, rst_n : system clock, async active-low reset.
//   en         : run the divider; when low the counter clears and sclk is held low.
//   sclk       : serial clock (registered), DIV clk low then DIV clk high.
//   rise, fall : one-cycle strobes, high on the clk edge at which sclk toggles.
module jt5911_sclkgen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 2;

  logic [CW-1:0] cnt_r;
  logic          sclk_r;
  logic          wrap_s;

  assign wrap_s = en && (cnt_r == CW'(DIV - 1));
  assign rise   = wrap_s && !sclk_r;
  assign fall   = wrap_s && sclk_r;
  assign sclk   = sclk_r;

  // Half-period counter and sclk toggle flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      sclk_r <= 1'b0;
    end else if (!en) begin
      cnt_r  <= '0;
      sclk_r <= 1'b0;
    end else if (wrap_s) begin
      cnt_r  <= '0;
      sclk_r <= !sclk_r;
    end else begin
      cnt_r  <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/jt5911_host.sv
// jt5911_host: host-side controller for a 93C46/ER5911-style serial EEPROM.
// Turns single-word CPU requests into sclk/sdi/scs frames, samples sdo on
// reads and polls rdy after erase-all.
//   clk, rst_n  : system clock, async active-low reset.
//   req/op      : request strobe and operation (0 READ .. 4 ERAL, 5-7 illegal).
//   addr/wdata  : word address and write data, latched on acceptance.
//   rdata       : last completed READ result.
//   busy/done/err : request in flight, end-of-request pulse, error (with done).
//   sclk/sdi/scs : serial clock, data to EEPROM, chip select.
//   sdo/rdy     : serial data from EEPROM, EEPROM ready.
module jt5911_host
  import jteeprom_pkg::*;
#(
  parameter  int PROG = 0,
  parameter  int DIV  = 4,
  parameter  int TOUT = 1024,
  localparam int AW   = addr_w(PROG),
  localparam int DW   = data_w(PROG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [2:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          sclk,
  output logic          sdi,
  input  logic          sdo,
  output logic          scs,
  input  logic          rdy
);

  localparam int FL   = 1 + cmd_len(PROG);           // start bit + command
  localparam int SW   = (FL > DW) ? FL : DW;         // shared shift register
  localparam int TMAX = (TOUT > 2 * DIV) ? TOUT : 2 * DIV;
  localparam int TW   = $clog2(TMAX + 1);

  state_e        state_r, state_nx_s;
  logic          accept_s, illegal_s, en_s, rise_s, fall_s, use_addr_s;
  logic [2:0]    op_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r, rsh_r, rdata_r;
  logic [FL-1:0] frame_s;
  logic [SW-1:0] sh_r, sh_ld_s, wd_ld_s;
  logic [4:0]    bcnt_r;
  logic [TW-1:0] tcnt_r;
  logic [1:0]    gap_r;
  logic          to_r, busy_r, done_r, err_r, sdi_r, scs_r;

  assign use_addr_s = (op_r == OP_READ) || (op_r == OP_WRITE);
  assign frame_s    = (FL'(1'b1) << (FL - 1))
                    | (FL'(opcode_of(op_r)) << AW)
                    | (use_addr_s ? FL'(addr_r) : {FL{1'b0}});
  // Both loads are MSB-aligned so the next bit is always sh_r[SW-1].
  assign sh_ld_s    = SW'(frame_s) << (SW - FL);
  assign wd_ld_s    = SW'(wdata_r) << (SW - DW);

  jt5911_sclkgen #(.DIV(DIV)) u_sclkgen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_s),
    .sclk  (sclk),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode and divider enable.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    illegal_s  = 1'b0;
    en_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          if (op_legal(op)) begin
            accept_s   = 1'b1;
            state_nx_s = ST_SEL;
          end else begin
            illegal_s  = 1'b1;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SEL: begin
        en_s = 1'b1;
        if (fall_s) begin
          state_nx_s = ST_CMD;
        end else begin
          state_nx_s = ST_SEL;
        end
      end
      ST_CMD: begin
        en_s = 1'b1;
        if (fall_s && (bcnt_r == 5'd0)) begin
          case (op_r)
            OP_READ:  state_nx_s = ST_RDAT;
            OP_WRITE: state_nx_s = ST_WDAT;
            OP_ERAL:  state_nx_s = ST_BUSYW;
            default:  state_nx_s = ST_DESEL;
          endcase
        end else begin
          state_nx_s = ST_CMD;
        end
      end
      ST_RDAT, ST_WDAT: begin
        en_s = 1'b1;
        if (fall_s && (bcnt_r == 5'd0)) begin
          state_nx_s = ST_DESEL;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_BUSYW: begin
        // rdy is only trusted once it has had 2 clk to fall after the last rise.
        if ((rdy && (gap_r == 2'd2)) || (tcnt_r == TW'(TOUT - 1))) begin
          state_nx_s = ST_DESEL;
        end else begin
          state_nx_s = ST_BUSYW;
        end
      end
      ST_DESEL: begin
        if (tcnt_r == TW'(2 * DIV - 1)) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DESEL;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Clk cycles since the last sclk rise, saturating at 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_r <= 2'd2;
    end else if (rise_s) begin
      gap_r <= 2'd0;
    end else if (gap_r != 2'd2) begin
      gap_r <= gap_r + 2'd1;
    end else begin
      gap_r <= gap_r;
    end
  end

  // Request latches, shifters, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= 3'd0;
      addr_r  <= '0;
      wdata_r <= '0;
      sh_r    <= '0;
      rsh_r   <= '0;
      rdata_r <= '0;
      bcnt_r  <= 5'd0;
      tcnt_r  <= '0;
      to_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      sdi_r   <= 1'b0;
      scs_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= (state_nx_s != ST_IDLE);
      scs_r  <= (state_nx_s inside {ST_SEL, ST_CMD, ST_RDAT, ST_WDAT, ST_BUSYW});
      case (state_r)
        ST_IDLE: begin
          sdi_r <= 1'b0;
          if (accept_s) begin
            op_r    <= op;
            addr_r  <= addr;
            wdata_r <= wdata;
            to_r    <= 1'b0;
          end
          if (illegal_s) begin
            done_r <= 1'b1;
            err_r  <= 1'b1;
          end
        end
        ST_SEL: begin
          // sdi stays low across this rise so the slave sees a clean start edge.
          if (fall_s) begin
            sdi_r  <= sh_ld_s[SW-1];
            sh_r   <= sh_ld_s << 1;
            bcnt_r <= 5'(FL - 1);
          end
        end
        ST_CMD: begin
          if (fall_s) begin
            if (bcnt_r == 5'd0) begin
              tcnt_r <= '0;
              bcnt_r <= 5'(DW - 1);
              if (op_r == OP_WRITE) begin
                sdi_r <= wd_ld_s[SW-1];
                sh_r  <= wd_ld_s << 1;
              end else begin
                sdi_r <= 1'b0;
              end
            end else begin
              sdi_r  <= sh_r[SW-1];
              sh_r   <= sh_r << 1;
              bcnt_r <= bcnt_r - 5'd1;
            end
          end
        end
        ST_RDAT: begin
          if (fall_s) begin
            rsh_r <= {rsh_r[DW-2:0], sdo};
            if (bcnt_r == 5'd0) begin
              rdata_r <= {rsh_r[DW-2:0], sdo};
              tcnt_r  <= '0;
            end else begin
              bcnt_r  <= bcnt_r - 5'd1;
            end
          end
        end
        ST_WDAT: begin
          if (fall_s) begin
            if (bcnt_r == 5'd0) begin
              sdi_r  <= 1'b0;
              tcnt_r <= '0;
            end else begin
              sdi_r  <= sh_r[SW-1];
              sh_r   <= sh_r << 1;
              bcnt_r <= bcnt_r - 5'd1;
            end
          end
        end
        ST_BUSYW: begin
          if (state_nx_s == ST_DESEL) begin
            to_r   <= !(rdy && (gap_r == 2'd2));
            tcnt_r <= '0;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        ST_DESEL: begin
          sdi_r  <= 1'b0;
          tcnt_r <= tcnt_r + TW'(1);
        end
        ST_DONE: begin
          done_r <= 1'b1;
          err_r  <= to_r;
        end
        default: begin
          sdi_r <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = rdata_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign err   = err_r;
  assign sdi   = sdi_r;
  assign scs   = scs_r;

endmodule

// File: tb/tb_jt5911_host.sv
// tb_jt5911_host: two hosts (PROG=0 and PROG=1, DIV=4, TOUT=1024), each wired
// to a small behavioural Microwire EEPROM preset to all 1s.
module tb_jt5911_host;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic [2:0]  op    [2];
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];
  logic        stuck [2];
  logic [15:0] rdata_w [2];
  logic        busy_w [2], done_w [2], err_w [2];
  logic        sclk_w [2], sdi_w [2], scs_w [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int AWg = (g != 0) ? 6 : 7;
    localparam int DWg = (g != 0) ? 16 : 8;
    localparam int CLg = (g != 0) ? 12 : 11;

    logic [DWg-1:0] rd_s;
    logic busy_s, done_s, err_s, sclk_s, sdi_s, scs_s, rdy_s;
    logic sdo_r = 1'b0;

    jt5911_host #(.PROG(g), .DIV(4), .TOUT(1024)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req[g]),
      .op    (op[g]),
      .addr  (addr[g][AWg-1:0]),
      .wdata (wdata[g][DWg-1:0]),
      .rdata (rd_s),
      .busy  (busy_s),
      .done  (done_s),
      .err   (err_s),
      .sclk  (sclk_s),
      .sdi   (sdi_s),
      .sdo   (sdo_r),
      .scs   (scs_s),
      .rdy   (rdy_s)
    );

    assign rdata_w[g] = 16'(rd_s);
    assign busy_w[g]  = busy_s;
    assign done_w[g]  = done_s;
    assign err_w[g]   = err_s;
    assign sclk_w[g]  = sclk_s;
    assign sdi_w[g]   = sdi_s;
    assign scs_w[g]   = scs_s;

    // Behavioural EEPROM slave
    logic [DWg-1:0] mem [1<<AWg];
    logic           mem_init = 1'b0;
    logic           sclk_q = 1'b0, started = 1'b0, ewen = 1'b0;
    int             nb = 0, phase = 0, bsy = 0;
    logic [15:0]    sh = 16'h0;
    logic [DWg-1:0] rsh, wsh;
    logic [AWg-1:0] waddr;
    logic [CLg-1:0] cw_s;

    assign cw_s  = {sh[CLg-2:0], sdi_s};
    assign rdy_s = !stuck[g] && (bsy == 0);

    // Slave: sample sdi one clk after each sclk rise, update sdo there too.
    always @(posedge clk) begin
      sclk_q <= sclk_s;
      if (!mem_init) begin
        for (int i = 0; i < (1 << AWg); i++) mem[i] <= '1;
        mem_init <= 1'b1;
      end
      if (bsy > 0) bsy <= bsy - 1;
      if (!scs_s) begin
        started <= 1'b0;
        nb      <= 0;
        phase   <= 0;
        sdo_r   <= 1'b0;
      end else if (sclk_s && !sclk_q) begin
        case (phase)
          0: begin
            if (!started) begin
              started <= sdi_s;
              nb      <= 0;
            end else begin
              sh <= {sh[14:0], sdi_s};
              nb <= nb + 1;
              if (nb == CLg - 1) begin
                phase <= 3;
                case (cw_s[AWg+3:AWg])
                  4'b1000: begin phase <= 1; rsh <= mem[cw_s[AWg-1:0]]; sdo_r <= 1'b0; end
                  4'b0100: begin phase <= 2; waddr <= cw_s[AWg-1:0]; nb <= 0; end
                  4'b0011: ewen <= 1'b1;
                  4'b0000: ewen <= 1'b0;
                  4'b0010: if (ewen) begin
                    for (int i = 0; i < (1 << AWg); i++) mem[i] <= '1;
                    bsy <= 150;
                  end
                  default: ;
                endcase
              end
            end
          end
          1: begin
            sdo_r <= rsh[DWg-1];
            rsh   <= rsh << 1;
          end
          2: begin
            wsh <= {wsh[DWg-2:0], sdi_s};
            nb  <= nb + 1;
            if (nb == DWg - 1) begin
              if (ewen) mem[waddr] <= {wsh[DWg-2:0], sdi_s};
              phase <= 3;
            end
          end
          default: ;
        endcase
      end
    end

    // Bus monitors (cumulative counters)
    logic sdi_q2 = 1'b0, scs_q2 = 1'b0, sclk_q2 = 1'b0;
    int viol = 0, done_cnt = 0, sclk_rise = 0, busy_hi = 0, hold = 0;

    always @(negedge clk) begin
      if (scs_q2 && scs_s && (sdi_s !== sdi_q2) && !(sclk_q2 && !sclk_s)) viol <= viol + 1;
      if (done_s === 1'b1) done_cnt <= done_cnt + 1;
      if (sclk_s === 1'b1 && sclk_q2 === 1'b0) sclk_rise <= sclk_rise + 1;
      if (busy_s === 1'b1) busy_hi <= busy_hi + 1;
      if (scs_s === 1'b1 && rdy_s === 1'b0) hold <= hold + 1;
      sdi_q2  <= sdi_s;
      scs_q2  <= scs_s;
      sclk_q2 <= sclk_s;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_req(input int g, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] d, output int lat,
                        output logic [15:0] rd, output logic e);
    @(negedge clk);
    req[g] = 1'b1; op[g] = o; addr[g] = a; wdata[g] = d;
    @(posedge clk);
    @(negedge clk);
    req[g] = 1'b0;
    lat = 0;
    while (done_w[g] !== 1'b1 && lat < 3000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rd = rdata_w[g];
    e  = err_w[g];
  endtask

  typedef struct {
    int          g;
    logic [2:0]  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt [13];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          lat, h0, d0, s0, b0;
    logic [15:0] rd;
    logic        e;

    vt[0]  = '{0, 3'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0, 113};  // EWEN
    vt[1]  = '{0, 3'd1, 16'h0015, 16'h00A5, 16'h0000, 1'b0, 177};  // WRITE
    vt[2]  = '{0, 3'd0, 16'h0015, 16'h0000, 16'h00A5, 1'b0, 177};  // READ
    vt[3]  = '{0, 3'd3, 16'h0000, 16'h0000, 16'h00A5, 1'b0, 113};  // EWDS
    vt[4]  = '{0, 3'd1, 16'h0020, 16'h003C, 16'h00A5, 1'b0, 177};  // WRITE (protected)
    vt[5]  = '{0, 3'd0, 16'h0020, 16'h0000, 16'h00FF, 1'b0, 177};  // READ -> FF
    vt[6]  = '{0, 3'd0, 16'h0015, 16'h0000, 16'h00A5, 1'b0, 177};  // READ back
    vt[7]  = '{0, 3'd6, 16'h0015, 16'h0000, 16'h00A5, 1'b1, 0};    // illegal 6
    vt[8]  = '{0, 3'd7, 16'h0000, 16'h0000, 16'h00A5, 1'b1, 0};    // illegal 7
    vt[9]  = '{1, 3'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0, 121};  // x16 EWEN
    vt[10] = '{1, 3'd1, 16'h0009, 16'h1234, 16'h0000, 1'b0, 249};  // x16 WRITE
    vt[11] = '{1, 3'd0, 16'h0009, 16'h0000, 16'h1234, 1'b0, 249};  // x16 READ
    vt[12] = '{1, 3'd0, 16'h000A, 16'h0000, 16'hFFFF, 1'b0, 249};  // x16 READ erased

    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req[g] = 1'b0; op[g] = 3'd0; addr[g] = 16'h0; wdata[g] = 16'h0; stuck[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("reset_ctl_g%0d", g),
          32'({busy_w[g], done_w[g], err_w[g], sclk_w[g], sdi_w[g], scs_w[g]}), 32'h0);
      chk($sformatf("reset_rdata_g%0d", g), 32'(rdata_w[g]), 32'h0);
    end

    for (int i = 0; i < 13; i++) begin
      do_req(vt[i].g, vt[i].op, vt[i].addr, vt[i].wdata, lat, rd, e);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].exp_rd));
    end

    // Illegal op: no bus activity, busy never set, done is a single pulse.
    s0 = gi[0].sclk_rise; b0 = gi[0].busy_hi; h0 = gi[0].hold;
    do_req(0, 3'd5, 16'h0001, 16'h0000, lat, rd, e);
    @(negedge clk);
    chk("illegal_done_pulse", 32'(done_w[0]), 32'h0);
    repeat (10) @(negedge clk);
    chk("illegal_err", 32'(e), 32'h1);
    chk("illegal_no_sclk", 32'(gi[0].sclk_rise - s0), 32'h0);
    chk("illegal_no_busy", 32'(gi[0].busy_hi - b0), 32'h0);
    chk("illegal_scs_low", 32'(scs_w[0]), 32'h0);

    // req while busy is dropped, not queued.
    d0 = gi[0].done_cnt;
    @(negedge clk);
    req[0] = 1'b1; op[0] = 3'd0; addr[0] = 16'h0015;
    @(negedge clk);
    req[0] = 1'b0;
    repeat (20) @(negedge clk);
    req[0] = 1'b1; op[0] = 3'd0; addr[0] = 16'h0020;
    @(negedge clk);
    req[0] = 1'b0;
    repeat (400) @(negedge clk);
    chk("busy_req_single_done", 32'(gi[0].done_cnt - d0), 32'h1);
    chk("busy_req_rdata", 32'(rdata_w[0]), 32'h00A5);

    // Reset mid-READ drops the bus at once; storage survives.
    @(negedge clk);
    req[0] = 1'b1; op[0] = 3'd0; addr[0] = 16'h0015;
    @(negedge clk);
    req[0] = 1'b0;
    repeat (60) @(negedge clk);
    chk("midread_scs_active", 32'(scs_w[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midreset_bus", 32'({scs_w[0], sclk_w[0], sdi_w[0], busy_w[0]}), 32'h0);
    chk("midreset_rdata", 32'(rdata_w[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 3'd0, 16'h0015, 16'h0000, lat, rd, e);
    chk("postreset_read", 32'(rd), 32'h00A5);
    chk("postreset_latency", 32'(lat), 32'd177);

    // ERAL with a responsive slave: scs held while rdy is low.
    do_req(0, 3'd2, 16'h0000, 16'h0000, lat, rd, e);
    h0 = gi[0].hold;
    do_req(0, 3'd4, 16'h0000, 16'h0000, lat, rd, e);
    chk("eral_done_seen", 32'(lat < 3000), 32'h1);
    chk("eral_err", 32'(e), 32'h0);
    chk("eral_scs_hold_ge128", 32'((gi[0].hold - h0) >= 128), 32'h1);
    do_req(0, 3'd0, 16'h0015, 16'h0000, lat, rd, e);
    chk("eral_read_erased", 32'(rd), 32'h00FF);

    // ERAL with rdy stuck low: timeout after TOUT cycles.
    stuck[0] = 1'b1;
    do_req(0, 3'd4, 16'h0000, 16'h0000, lat, rd, e);
    stuck[0] = 1'b0;
    chk("eral_timeout_err", 32'(e), 32'h1);
    chk("eral_timeout_latency", 32'(lat), 32'd1137);

    chk("sdi_only_on_fall_g0", 32'(gi[0].viol), 32'h0);
    chk("sdi_only_on_fall_g1", 32'(gi[1].viol), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
